// File: rtl/id_ibuf_decode_pkg.sv
// Shared opcode/func3 constants and ALU control encodings for the
// instruction-buffered decode stage.
package id_ibuf_decode_pkg;

  localparam logic [6:0] OPC_BTYPE   = 7'b1100011;
  localparam logic [6:0] OPC_JTYPE_J = 7'b1101111;
  localparam logic [6:0] OPC_ITYPE_J = 7'b1100111;
  localparam logic [6:0] OPC_UTYPE_L = 7'b0110111;
  localparam logic [6:0] OPC_UTYPE_A = 7'b0010111;
  localparam logic [6:0] OPC_ITYPE_A = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;

  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_ctrl_e;

  // alt selects SUB/SRA (instruction bit 30)
  function automatic alu_ctrl_e alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_ctrl_e alu_branch(input logic [2:0] f3);
    case (f3)
      3'b001:  return ALU_BNE;
      3'b100:  return ALU_BLT;
      3'b101:  return ALU_BGE;
      3'b110:  return ALU_BLTU;
      3'b111:  return ALU_BGEU;
      default: return ALU_BEQ;
    endcase
  endfunction

endpackage

// File: rtl/id_inst_queue.sv
// DEPTH-entry FIFO of {pc, instruction} beats; clear has priority over
// push and pop. Callers never push when full nor pop when empty.
module id_inst_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // NOTE: storage is deliberately not reset; validity lives only in count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/id_ibuf_decode.sv
// Instruction queue between fetch and decode, decoding the queue head into
// ALU operands/control with load-use stall, post-flush kill and jump squash.
module id_ibuf_decode
  import id_ibuf_decode_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter int KILL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid_i,
  input  logic [XLEN-1:0]  if_pc_i,
  input  logic [31:0]      if_inst_i,
  output logic             if_ready_o,
  input  logic             fc_flush_i,
  output logic [4:0]       regs_raddr1_o,
  output logic [4:0]       regs_raddr2_o,
  input  logic [XLEN-1:0]  regs_rdata1_i,
  input  logic [XLEN-1:0]  regs_rdata2_i,
  input  logic             fwd_sel1_i,
  input  logic             fwd_sel2_i,
  input  logic [XLEN-1:0]  fwd_data1_i,
  input  logic [XLEN-1:0]  fwd_data2_i,
  input  logic             ex_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_ready_i,
  output logic             id_valid_o,
  output logic [XLEN-1:0]  id_pc_o,
  output logic [XLEN-1:0]  id_op_a_o,
  output logic [XLEN-1:0]  id_op_b_o,
  output logic [4:0]       id_reg_waddr_o,
  output logic [4:0]       id_alu_ctrl_o,
  output logic             id_reg_we_o,
  output logic             id_reg1_re_o,
  output logic             id_reg2_re_o,
  output logic             id_btype_flag_o,
  output logic [XLEN-1:0]  id_btype_pc_o,
  output logic             id_jump_flag_o,
  output logic [XLEN-1:0]  id_jump_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int KILL_W = (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;

  logic [XLEN+31:0] q_rdata;
  logic q_full, q_empty, push, pop, clear, stall, head_valid;
  logic [KILL_W-1:0] kill_cnt;
  logic [XLEN-1:0] head_pc, rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] inst;
  logic is_jal, is_jalr, is_br, reg_we, reg1_re, reg2_re;
  logic [XLEN-1:0] op_a, op_b;
  alu_ctrl_e alu_ctrl;

  id_inst_queue #(.DEPTH(DEPTH), .W(XLEN + 32)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .wr_data ({if_pc_i, if_inst_i}),
    .rd_data (q_rdata),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign head_valid = !q_empty;
  assign head_pc    = q_rdata[XLEN+31:32];
  assign inst       = head_valid ? q_rdata[31:0] : 32'h0;

  assign regs_raddr1_o = inst[19:15];
  assign regs_raddr2_o = inst[24:20];
  assign rs1_val = fwd_sel1_i ? fwd_data1_i : regs_rdata1_i;
  assign rs2_val = fwd_sel2_i ? fwd_data2_i : regs_rdata2_i;

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    op_a     = rs1_val;
    op_b     = rs2_val;
    reg_we   = 1'b0;
    reg1_re  = 1'b0;
    reg2_re  = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    is_br    = 1'b0;
    alu_ctrl = ALU_ADD;
    case (inst[6:0])
      OPC_UTYPE_L: begin op_a = '0;      op_b = imm_u;        reg_we = 1'b1; end
      OPC_UTYPE_A: begin op_a = head_pc; op_b = imm_u;        reg_we = 1'b1; end
      OPC_JTYPE_J: begin op_a = head_pc; op_b = XLEN'(4);     reg_we = 1'b1; is_jal = 1'b1; end
      OPC_ITYPE_J: begin
        op_a = head_pc; op_b = XLEN'(4); reg_we = 1'b1; reg1_re = 1'b1; is_jalr = 1'b1;
      end
      OPC_BTYPE: begin
        reg1_re = 1'b1; reg2_re = 1'b1; is_br = 1'b1; alu_ctrl = alu_branch(inst[14:12]);
      end
      OPC_LOAD:  begin op_b = imm_i; reg_we = 1'b1; reg1_re = 1'b1; end
      OPC_STORE: begin op_b = imm_s; reg1_re = 1'b1; reg2_re = 1'b1; end
      OPC_ITYPE_A: begin
        reg_we  = 1'b1;
        reg1_re = 1'b1;
        op_b    = (inst[14:12] == F3_SLLI || inst[14:12] == F3_SRLI_SRAI)
                  ? XLEN'(inst[24:20]) : imm_i;
        alu_ctrl = alu_arith(inst[14:12], (inst[14:12] == F3_SRLI_SRAI) & inst[30]);
      end
      OPC_RTYPE: begin
        reg_we = 1'b1; reg1_re = 1'b1; reg2_re = 1'b1;
        alu_ctrl = alu_arith(inst[14:12], inst[30]);
      end
      default: ;
    endcase
  end

  assign stall = head_valid & ex_load_i & (ex_rd_i != 5'd0) &
                 ((reg1_re & (inst[19:15] == ex_rd_i)) | (reg2_re & (inst[24:20] == ex_rd_i)));

  assign id_valid_o = head_valid & !stall & !fc_flush_i;
  assign pop        = id_valid_o & ex_ready_i;
  assign if_ready_o = !q_full | (kill_cnt != '0);
  assign push       = if_valid_i & if_ready_o & !fc_flush_i & (kill_cnt == '0);
  // A popped jump makes every younger entry, and any same-cycle push, wrong-path.
  assign clear      = fc_flush_i | (pop & (is_jal | is_jalr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_cnt <= '0;
    end else if (fc_flush_i) begin
      kill_cnt <= KILL_W'(KILL_CYCLES);
    end else if (if_valid_i && kill_cnt != '0) begin
      kill_cnt <= kill_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (stall && !fc_flush_i && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  assign id_pc_o         = head_pc;
  assign id_op_a_o       = op_a;
  assign id_op_b_o       = op_b;
  assign id_reg_waddr_o  = inst[11:7];
  assign id_alu_ctrl_o   = alu_ctrl;
  assign id_reg_we_o     = reg_we;
  assign id_reg1_re_o    = reg1_re;
  assign id_reg2_re_o    = reg2_re;
  assign id_btype_flag_o = is_br & id_valid_o;
  assign id_btype_pc_o   = head_pc + imm_b;
  assign id_jump_flag_o  = (is_jal | is_jalr) & id_valid_o;
  assign id_jump_pc_o    = is_jalr ? (rs1_val + imm_i) : (head_pc + imm_j);

endmodule

// File: tb/tb_id_ibuf_decode.sv
// Directed bench for id_ibuf_decode: queueing, decode, load-use stall,
// jump squash, flush/kill and asynchronous reset.
module tb_id_ibuf_decode;
  import id_ibuf_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid_i, fc_flush_i, fwd_sel1_i, fwd_sel2_i, ex_load_i, ex_ready_i;
  logic [31:0] if_pc_i, if_inst_i, regs_rdata1_i, regs_rdata2_i, fwd_data1_i, fwd_data2_i;
  logic [4:0]  ex_rd_i, regs_raddr1_o, regs_raddr2_o, id_reg_waddr_o, id_alu_ctrl_o;
  logic        if_ready_o, id_valid_o, id_reg_we_o, id_reg1_re_o, id_reg2_re_o;
  logic        id_btype_flag_o, id_jump_flag_o;
  logic [31:0] id_pc_o, id_op_a_o, id_op_b_o, id_btype_pc_o, id_jump_pc_o;
  logic [15:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Register file model: x0 = 0, xN = N*16.
  assign regs_rdata1_i = {23'd0, regs_raddr1_o, 4'h0};
  assign regs_rdata2_i = {23'd0, regs_raddr2_o, 4'h0};

  id_ibuf_decode #(.XLEN(32), .DEPTH(4), .KILL_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .if_ready_o(if_ready_o),
    .fc_flush_i(fc_flush_i),
    .regs_raddr1_o(regs_raddr1_o), .regs_raddr2_o(regs_raddr2_o),
    .regs_rdata1_i(regs_rdata1_i), .regs_rdata2_i(regs_rdata2_i),
    .fwd_sel1_i(fwd_sel1_i), .fwd_sel2_i(fwd_sel2_i),
    .fwd_data1_i(fwd_data1_i), .fwd_data2_i(fwd_data2_i),
    .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i), .ex_ready_i(ex_ready_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_op_a_o(id_op_a_o), .id_op_b_o(id_op_b_o),
    .id_reg_waddr_o(id_reg_waddr_o), .id_alu_ctrl_o(id_alu_ctrl_o), .id_reg_we_o(id_reg_we_o),
    .id_reg1_re_o(id_reg1_re_o), .id_reg2_re_o(id_reg2_re_o),
    .id_btype_flag_o(id_btype_flag_o), .id_btype_pc_o(id_btype_pc_o),
    .id_jump_flag_o(id_jump_flag_o), .id_jump_pc_o(id_jump_pc_o),
    .stall_cnt_o(stall_cnt_o)
  );

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] pc, input logic [31:0] inst);
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst;
    tick();
    if_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", if_ready_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt_o); end
    checks++; if ({id_jump_flag_o, id_btype_flag_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {id_jump_flag_o, id_btype_flag_o}); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_addi;
    ex_ready_i = 1'b1;
    push_beat(32'h100, 32'h00500093);
    #1;
    checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", id_valid_o); end
    checks++; if (id_pc_o !== 32'h100) begin errors++; $display("FAIL addi_pc: got %h want 00000100", id_pc_o); end
    checks++; if (id_op_a_o !== 32'h0) begin errors++; $display("FAIL addi_op_a: got %h want 0", id_op_a_o); end
    checks++; if (id_op_b_o !== 32'h5) begin errors++; $display("FAIL addi_op_b: got %h want 5", id_op_b_o); end
    checks++; if (id_reg_waddr_o !== 5'd1) begin errors++; $display("FAIL addi_waddr: got %0d want 1", id_reg_waddr_o); end
    checks++; if (id_reg_we_o !== 1'b1) begin errors++; $display("FAIL addi_we: got %b want 1", id_reg_we_o); end
    checks++; if (id_alu_ctrl_o !== 5'(ALU_ADD)) begin errors++; $display("FAIL addi_alu: got %0d want %0d", id_alu_ctrl_o, 5'(ALU_ADD)); end
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL addi_drained: got %b want 0", id_valid_o); end
  endtask

  task automatic test_fill_drain;
    ex_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(32'h110 + 32'(4*i), addi(5'(i+1), 12'(i+1)));
    #1;
    checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", if_ready_o); end
    ex_ready_i = 1'b1;
    #1;
    checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b want 0", if_ready_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h110 + 32'(4*i)) begin
        errors++; $display("FAIL drain_order[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, id_valid_o, id_pc_o, 32'h110 + 32'(4*i));
      end
      checks++; if (id_op_b_o !== 32'(i+1)) begin errors++; $display("FAIL drain_op_b[%0d]: got %h want %h", i, id_op_b_o, 32'(i+1)); end
      tick();
    end
    checks++; if (id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin errors++; $display("FAIL drain_empty: got valid=%b ready=%b want 0/1", id_valid_o, if_ready_o); end
  endtask

  task automatic test_load_use;
    ex_ready_i = 1'b1;
    ex_load_i  = 1'b1;
    ex_rd_i    = 5'd3;
    push_beat(32'h300, 32'h00218233);  // ADD x4,x3,x2
    #1;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid0: got %b want 0", id_valid_o); end
    tick();
    checks++; if (id_valid_o !== 1'b0 || stall_cnt_o !== 16'd1) begin errors++; $display("FAIL stall_cnt1: got valid=%b cnt=%0d want 0/1", id_valid_o, stall_cnt_o); end
    tick();
    checks++; if (stall_cnt_o !== 16'd2) begin errors++; $display("FAIL stall_cnt2: got %0d want 2", stall_cnt_o); end
    ex_rd_i     = 5'd0;  // load targeting x0 never stalls
    fwd_sel1_i  = 1'b1;
    fwd_data1_i = 32'hDEAD;
    #1;
    checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL stall_x0_valid: got %b want 1", id_valid_o); end
    checks++; if (id_op_a_o !== 32'hDEAD) begin errors++; $display("FAIL fwd_op_a: got %h want 0000dead", id_op_a_o); end
    checks++; if (id_op_b_o !== 32'h20) begin errors++; $display("FAIL add_op_b: got %h want 00000020", id_op_b_o); end
    fwd_sel1_i = 1'b0;
    ex_load_i  = 1'b0;
    #1;
    checks++; if (id_op_a_o !== 32'h30) begin errors++; $display("FAIL add_op_a: got %h want 00000030", id_op_a_o); end
    tick();
    checks++; if (id_valid_o !== 1'b0 || stall_cnt_o !== 16'd2) begin errors++; $display("FAIL stall_after: got valid=%b cnt=%0d want 0/2", id_valid_o, stall_cnt_o); end
  endtask

  task automatic test_jump_squash;
    ex_ready_i = 1'b0;
    push_beat(32'h200, 32'h040000EF);  // JAL x1,+0x40
    push_beat(32'h204, addi(5'd2, 12'd2));
    push_beat(32'h208, addi(5'd3, 12'd3));
    #1;
    checks++; if (id_jump_flag_o !== 1'b1) begin errors++; $display("FAIL jal_flag: got %b want 1", id_jump_flag_o); end
    checks++; if (id_jump_pc_o !== 32'h240) begin errors++; $display("FAIL jal_target: got %h want 00000240", id_jump_pc_o); end
    checks++; if (id_op_a_o !== 32'h200 || id_op_b_o !== 32'h4) begin errors++; $display("FAIL jal_ops: got a=%h b=%h want 00000200/00000004", id_op_a_o, id_op_b_o); end
    ex_ready_i = 1'b1;
    if_valid_i = 1'b1;  // same-cycle push is wrong-path
    if_pc_i    = 32'h20C;
    if_inst_i  = addi(5'd4, 12'd4);
    tick();
    if_valid_i = 1'b0;
    #1;
    checks++; if (id_valid_o !== 1'b0 || id_jump_flag_o !== 1'b0) begin errors++; $display("FAIL jal_squash: got valid=%b jump=%b want 0/0", id_valid_o, id_jump_flag_o); end
    ex_ready_i = 1'b0;
    push_beat(32'h600, 32'h010280E7);  // JALR x1,0x10(x5)
    #1;
    checks++; if (id_jump_pc_o !== 32'h60 || id_op_a_o !== 32'h600) begin errors++; $display("FAIL jalr_target: got pc=%h a=%h want 00000060/00000600", id_jump_pc_o, id_op_a_o); end
    ex_ready_i = 1'b1;
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL jalr_pop: got %b want 0", id_valid_o); end
  endtask

  task automatic test_branch_shift;
    ex_ready_i = 1'b0;
    push_beat(32'h400, 32'h00208463);  // BEQ x1,x2,+8
    push_beat(32'h404, 32'h4030D313);  // SRAI x6,x1,3
    #1;
    checks++; if (id_btype_flag_o !== 1'b1 || id_btype_pc_o !== 32'h408) begin errors++; $display("FAIL beq_target: got flag=%b pc=%h want 1/00000408", id_btype_flag_o, id_btype_pc_o); end
    checks++; if (id_reg_we_o !== 1'b0 || id_alu_ctrl_o !== 5'(ALU_BEQ)) begin errors++; $display("FAIL beq_ctrl: got we=%b alu=%0d want 0/%0d", id_reg_we_o, id_alu_ctrl_o, 5'(ALU_BEQ)); end
    checks++; if (id_op_a_o !== 32'h10 || id_op_b_o !== 32'h20) begin errors++; $display("FAIL beq_ops: got a=%h b=%h want 00000010/00000020", id_op_a_o, id_op_b_o); end
    ex_ready_i = 1'b1;
    tick();
    checks++; if (id_op_b_o !== 32'h3 || id_alu_ctrl_o !== 5'(ALU_SRA)) begin errors++; $display("FAIL srai: got b=%h alu=%0d want 00000003/%0d", id_op_b_o, id_alu_ctrl_o, 5'(ALU_SRA)); end
    checks++; if (id_btype_flag_o !== 1'b0 || id_reg_waddr_o !== 5'd6) begin errors++; $display("FAIL srai_misc: got br=%b rd=%0d want 0/6", id_btype_flag_o, id_reg_waddr_o); end
    tick();
  endtask

  task automatic test_flush_kill;
    ex_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push_beat(32'h700 + 32'(4*i), addi(5'(i+1), 12'd1));
    fc_flush_i = 1'b1;
    #1;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_override: got %b want 0", id_valid_o); end
    tick();
    fc_flush_i = 1'b0;
    #1;
    checks++; if (id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin errors++; $display("FAIL flush_cleared: got valid=%b ready=%b want 0/1", id_valid_o, if_ready_o); end
    push_beat(32'h500, addi(5'd7, 12'd1));  // A: dropped by kill
    push_beat(32'h504, addi(5'd8, 12'd2));  // B: accepted
    #1;
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h504 || id_reg_waddr_o !== 5'd8) begin
      errors++; $display("FAIL kill_b_issue: got valid=%b pc=%h rd=%0d want 1/00000504/8", id_valid_o, id_pc_o, id_reg_waddr_o);
    end
    ex_ready_i = 1'b1;
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL kill_empty: got %b want 0", id_valid_o); end
  endtask

  task automatic test_reset_mid;
    ex_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(32'h800 + 32'(4*i), addi(5'd1, 12'd1));
    #1;
    checks++; if (if_ready_o !== 1'b0 || stall_cnt_o !== 16'd2) begin errors++; $display("FAIL pre_reset: got ready=%b cnt=%0d want 0/2", if_ready_o, stall_cnt_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin errors++; $display("FAIL async_reset: got valid=%b ready=%b want 0/1", id_valid_o, if_ready_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d want 0", stall_cnt_o); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_empty: got %b want 0", id_valid_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    if_valid_i = 1'b0; if_pc_i = '0; if_inst_i = '0; fc_flush_i = 1'b0;
    fwd_sel1_i = 1'b0; fwd_sel2_i = 1'b0; fwd_data1_i = '0; fwd_data2_i = '0;
    ex_load_i = 1'b0; ex_rd_i = '0; ex_ready_i = 1'b0;
    test_reset();
    test_addi();
    test_fill_drain();
    test_load_use();
    test_jump_squash();
    test_branch_shift();
    test_flush_kill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ibuf_decode.md
Name: id_ibuf_decode

Overview:
- Parametrised successor of the single-instruction decode stage.
- Holds fetched instructions in a DEPTH-entry instruction queue between Icache/fetch and the decoder, then decodes the queue head into ALU operands and control.
- Uses valid/ready handshakes on both sides, detects load-use hazards internally, and supports configurable post-jump kill cycles and self-squash.
- Sits between fetch (fc/Icache) and id_ex_reg, replacing the fixed one-cycle delay_flag scheme.

Parameters:
- XLEN, 32, datapath and PC width.
- DEPTH, 4, queue entries; power of 2, at least 2.
- KILL_CYCLES, 1, fetch beats discarded after fc_flush_i; 0 disables.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_valid_i  in  1  fetch beat valid
- if_pc_i  in  XLEN  PC of the fetch beat
- if_inst_i  in  32  instruction word
- if_ready_o  out  1  queue can accept a beat
- fc_flush_i  in  1  redirect from flow control
- regs_raddr1_o / regs_raddr2_o  out  5  rs1/rs2 of the head instruction
- regs_rdata1_i / regs_rdata2_i  in  XLEN  register file read data
- fwd_sel1_i / fwd_sel2_i  in  1  forwarding select
- fwd_data1_i / fwd_data2_i  in  XLEN  forwarded data
- ex_load_i  in  1  EX holds a load
- ex_rd_i  in  5  destination register of the EX instruction
- ex_ready_i  in  1  id_ex_reg accepts this cycle
- id_valid_o  out  1  decoded instruction valid
- id_pc_o  out  XLEN  PC of the issued instruction
- id_op_a_o / id_op_b_o  out  XLEN  ALU operands
- id_reg_waddr_o  out  5  rd
- id_alu_ctrl_o  out  5  ALU control
- id_reg_we_o  out  1  register write enable
- id_reg1_re_o / id_reg2_re_o  out  1  source-register read enables
- id_btype_flag_o  out  1  branch instruction
- id_btype_pc_o  out  XLEN  PC plus B-immediate
- id_jump_flag_o  out  1  JAL/JALR issued
- id_jump_pc_o  out  XLEN  jump target
- stall_cnt_o  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset values: queue empty (rd_ptr = wr_ptr = count = 0); kill_cnt = 0; stall_cnt_o = 0; if_ready_o = 1; id_valid_o = 0, id_jump_flag_o = 0, id_btype_flag_o = 0.
- Push:
  - push = if_valid_i & if_ready_o & !fc_flush_i & kill_cnt==0.
  - if_ready_o = (count != DEPTH) | (kill_cnt != 0). Beats accepted during kill are dropped.
- Latency: a beat pushed in cycle N is decodable at the head in cycle N+1 at the earliest. There is no bypass; a full queue with a simultaneous pop still deasserts if_ready_o.
- Decode:
  - Combinational from the head entry. When the queue is empty the head word reads as 32'h0, so all flags are 0.
  - Operand, immediate, branch and jump rules are unchanged from the current stage:
    - LUI: op_a = 0. AUIPC/JAL/JALR: op_a = pc.
    - JAL/JALR: op_b = 4. SLLI/SRLI/SRAI: op_b = zero-extended shamt.
    - JAL target = pc + imm. JALR target = rs1 + imm, rs1 after forwarding.
    - Forwarding mux is applied before any use of rs1/rs2.
- Load-use stall:
  - stall = head_valid & ex_load_i & ex_rd_i != 0 & ((reg1_re & rs1 == ex_rd_i) | (reg2_re & rs2 == ex_rd_i)).
- Issue:
  - id_valid_o = head_valid & !stall & !fc_flush_i.
  - pop = id_valid_o & ex_ready_i.
  - id_jump_flag_o and id_btype_flag_o are gated by id_valid_o.
- Self-squash: when a JAL/JALR pops, all younger entries are discarded on the next edge, and a same-cycle push is discarded too (wrong path).
- Flush (fc_flush_i):
  - Next edge: queue cleared and kill_cnt loaded with KILL_CYCLES.
  - kill_cnt decrements once per cycle in which if_valid_i is high, saturating at 0.
  - Flush overrides push, pop and stall in the same cycle.
- Stall counter: stall_cnt_o increments each cycle with stall = 1 and saturates at all-ones.
- Pointers: log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation: every state returns to its reset value immediately (asynchronous).

Decomposition:
- Shared package `define.v` holds the opcode/func3 constants (Btype, Jtype_J, Itype_J, Utype_L, Utype_A, Itype_A, I_SLLI, I_SRLI_SRAI) and the ALU control encodings.
- The existing cu and eximm are reused unchanged.
- One new sub-module, id_inst_queue: a DEPTH × (XLEN+32) FIFO with push, pop, clear, count, full and empty.

Test Plan:
- Reset, then push ADDI x1,x0,5 at pc 0x100 with ex_ready_i=1 -> next cycle id_valid_o=1, op_a=0, op_b=5, waddr=1, we=1.
- Push 4 beats with ex_ready_i=0, DEPTH=4 -> if_ready_o=0 after the 4th; release ex_ready_i -> issue in order, one per cycle.
- ex_load_i=1, ex_rd_i=3, head ADD x4,x3,x2 -> id_valid_o=0 and stall_cnt_o increments; drop ex_load_i -> issues next cycle.
- JAL at pc 0x200 with imm 0x40, two younger entries queued -> id_jump_flag_o=1, id_jump_pc_o=0x240, op_b=4; queue empty next cycle.
- fc_flush_i with 3 entries, KILL_CYCLES=1, then beats A and B -> queue empties, A dropped, B issued.
- Assert rst_n low while queue is full -> count=0, id_valid_o=0 and if_ready_o=1 immediately.
